// File: rtl/search_pkg.sv
// Shared types and defaults for the binary-search request front end.
package search_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HOLD,
      S_ERR
   } req_state_t;

   localparam int DEF_VAL_WIDTH = 8;
   localparam int SYNC_STAGES   = 2;

endpackage

// File: rtl/search_req_ctrl_debounce.sv
// Synchronizes one raw switch into the clock domain and only lets the level
// through once it has been stable for DB_CYCLES consecutive cycles.
module debounce
   import search_pkg::*;
#(
   parameter int DB_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   din_s;

   // Shift the raw input through the synchronizer and count how long it has disagreed with the held level.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], din};
      din_s   = sync_q[SYNC_STAGES-1];
      level_d = level_q;
      cnt_d   = '0;
      if (din_s != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = din_s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Register synchronizer, stability counter and debounced level.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign dout = level_q;

endmodule

// File: rtl/search_req_ctrl.sv
// Front end for the RAM binary searcher: turns the board switches into one
// clean search request per switch action and latches the searcher's result.
module search_req_ctrl
   import search_pkg::*;
#(
   parameter int VAL_WIDTH = DEF_VAL_WIDTH,
   parameter int DB_CYCLES = 500000,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [VAL_WIDTH-1:0] sw_val,
   input  logic                 sw_en,
   input  logic                 search_done,
   input  logic                 search_found,
   output logic [VAL_WIDTH-1:0] A,
   output logic                 en,
   output logic                 busy,
   output logic                 result_valid,
   output logic                 found,
   output logic                 err
);

   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   req_state_t state_q, state_d;
   logic [VAL_WIDTH-1:0] val_s1_q, val_s2_q;
   logic [VAL_WIDTH-1:0] a_q, a_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic en_lvl, en_lvl_prev_q, trig;
   logic en_q, en_d, busy_q, busy_d, valid_q, valid_d;
   logic found_q, found_d, err_q, err_d;

   debounce #(.DB_CYCLES(DB_CYCLES)) u_en_db (
      .clock (clock),
      .reset (reset),
      .din   (sw_en),
      .dout  (en_lvl)
   );

   // Next-state logic; every output flop is a function of the next state so nothing combinational reaches a port.
   always_comb begin
      trig    = en_lvl & ~en_lvl_prev_q;
      state_d = state_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      found_d = found_q;
      case (state_q)
         S_IDLE: begin
            if (trig) begin
               a_d     = val_s2_q;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (search_done) begin
               found_d = search_found;
               state_d = S_HOLD;
            end else if (!en_lvl) begin
               state_d = S_IDLE;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_ERR;
            end
         end
         S_HOLD: begin
            if (!en_lvl) begin
               found_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_ERR: begin
            if (!en_lvl) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      en_d    = (state_d == S_RUN) || (state_d == S_HOLD);
      busy_d  = (state_d == S_RUN);
      valid_d = (state_d == S_HOLD);
      err_d   = (state_d == S_ERR);
   end

   // State, captured value, timeout counter, synchronizers and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         val_s1_q      <= '0;
         val_s2_q      <= '0;
         a_q           <= '0;
         cnt_q         <= '0;
         en_lvl_prev_q <= 1'b0;
         en_q          <= 1'b0;
         busy_q        <= 1'b0;
         valid_q       <= 1'b0;
         found_q       <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         val_s1_q      <= sw_val;
         val_s2_q      <= val_s1_q;
         a_q           <= a_d;
         cnt_q         <= cnt_d;
         en_lvl_prev_q <= en_lvl;
         en_q          <= en_d;
         busy_q        <= busy_d;
         valid_q       <= valid_d;
         found_q       <= found_d;
         err_q         <= err_d;
      end
   end

   assign A            = a_q;
   assign en           = en_q;
   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign found        = found_q;
   assign err          = err_q;

endmodule

// File: tb/tb_search_req_ctrl.sv
// Directed bench for search_req_ctrl with a short debounce and timeout.
module tb_search_req_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] sw_val;
   logic       sw_en;
   logic       search_done;
   logic       search_found;
   logic [7:0] A;
   logic       en, busy, result_valid, found, err;

   int checks = 0;
   int errors = 0;
   logic sticky;

   search_req_ctrl #(.VAL_WIDTH(8), .DB_CYCLES(4), .TIMEOUT(64)) dut (
      .clock        (clock),
      .reset        (reset),
      .sw_val       (sw_val),
      .sw_en        (sw_en),
      .search_done  (search_done),
      .search_found (search_found),
      .A            (A),
      .en           (en),
      .busy         (busy),
      .result_valid (result_valid),
      .found        (found),
      .err          (err)
   );

   // Free-running 100 MHz-style clock.
   always #5 clock = ~clock;

   // Advance n active edges, leaving time 1 unit past the last edge.
   task automatic applyStimulus(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Linear directed sequence.
   initial begin
      reset = 1'b0;
      sw_val = 8'h00;
      sw_en = 1'b0;
      search_done = 1'b0;
      search_found = 1'b0;
      #1;
      checkOutput("reset_en", {31'b0, en}, 32'd0);
      checkOutput("reset_A", {24'b0, A}, 32'd0);
      applyStimulus(3);
      reset = 1'b1;
      applyStimulus(2);

      // Glitch: three cycles high must not pass the debouncer.
      sw_en = 1'b1;
      applyStimulus(3);
      sw_en = 1'b0;
      sticky = 1'b0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1);
         sticky = sticky | en;
      end
      checkOutput("glitch_en_never", {31'b0, sticky}, 32'd0);
      checkOutput("glitch_A", {24'b0, A}, 32'd0);

      // Normal search: en rises after edge k+7, not k+6.
      sw_val = 8'h2A;
      sw_en = 1'b1;
      applyStimulus(7);
      checkOutput("norm_en_k6", {31'b0, en}, 32'd0);
      applyStimulus(1);
      checkOutput("norm_en_k7", {31'b0, en}, 32'd1);
      checkOutput("norm_A", {24'b0, A}, 32'h2A);
      checkOutput("norm_busy", {31'b0, busy}, 32'd1);
      sw_val = 8'h55;
      applyStimulus(10);
      checkOutput("norm_A_stable", {24'b0, A}, 32'h2A);
      search_done = 1'b1;
      search_found = 1'b1;
      applyStimulus(1);
      checkOutput("norm_valid", {31'b0, result_valid}, 32'd1);
      checkOutput("norm_found", {31'b0, found}, 32'd1);
      checkOutput("norm_hold_en", {31'b0, en}, 32'd1);
      checkOutput("norm_hold_busy", {31'b0, busy}, 32'd0);
      sw_en = 1'b0;
      applyStimulus(7);
      checkOutput("norm_hold_late", {31'b0, result_valid}, 32'd1);
      applyStimulus(1);
      checkOutput("norm_idle_en", {31'b0, en}, 32'd0);
      checkOutput("norm_idle_valid", {31'b0, result_valid}, 32'd0);
      checkOutput("norm_idle_found", {31'b0, found}, 32'd0);
      search_done = 1'b0;
      search_found = 1'b0;

      // Timeout: 64 cycles in RUN then ERR.
      sw_en = 1'b1;
      applyStimulus(8);
      checkOutput("to_busy", {31'b0, busy}, 32'd1);
      applyStimulus(63);
      checkOutput("to_err_early", {31'b0, err}, 32'd0);
      checkOutput("to_busy_late", {31'b0, busy}, 32'd1);
      applyStimulus(1);
      checkOutput("to_err", {31'b0, err}, 32'd1);
      checkOutput("to_en", {31'b0, en}, 32'd0);
      applyStimulus(5);
      checkOutput("to_err_held", {31'b0, err}, 32'd1);
      sw_en = 1'b0;
      applyStimulus(8);
      checkOutput("to_err_clear", {31'b0, err}, 32'd0);
      checkOutput("to_idle_en", {31'b0, en}, 32'd0);

      // Abort during RUN, then a fresh capture.
      sw_val = 8'h11;
      sw_en = 1'b1;
      applyStimulus(8);
      checkOutput("ab_A1", {24'b0, A}, 32'h11);
      sw_en = 1'b0;
      sticky = 1'b0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1);
         sticky = sticky | result_valid;
      end
      checkOutput("ab_valid_never", {31'b0, sticky}, 32'd0);
      checkOutput("ab_busy", {31'b0, busy}, 32'd0);
      checkOutput("ab_en", {31'b0, en}, 32'd0);
      sw_val = 8'h3C;
      sw_en = 1'b1;
      applyStimulus(8);
      checkOutput("ab_A2", {24'b0, A}, 32'h3C);
      checkOutput("ab_en2", {31'b0, en}, 32'd1);

      // Done on the same cycle the debounced enable falls.
      sw_en = 1'b0;
      applyStimulus(7);
      checkOutput("sim1_busy", {31'b0, busy}, 32'd1);
      search_done = 1'b1;
      search_found = 1'b1;
      applyStimulus(1);
      checkOutput("sim1_valid", {31'b0, result_valid}, 32'd1);
      checkOutput("sim1_found", {31'b0, found}, 32'd1);
      applyStimulus(1);
      checkOutput("sim1_idle_valid", {31'b0, result_valid}, 32'd0);
      checkOutput("sim1_idle_en", {31'b0, en}, 32'd0);
      search_done = 1'b0;
      search_found = 1'b0;

      // Done on the same cycle the timeout would fire.
      sw_en = 1'b1;
      applyStimulus(8);
      checkOutput("sim2_busy", {31'b0, busy}, 32'd1);
      applyStimulus(63);
      search_done = 1'b1;
      applyStimulus(1);
      checkOutput("sim2_valid", {31'b0, result_valid}, 32'd1);
      checkOutput("sim2_err", {31'b0, err}, 32'd0);
      checkOutput("sim2_en", {31'b0, en}, 32'd1);
      sw_en = 1'b0;
      applyStimulus(8);
      search_done = 1'b0;
      checkOutput("sim2_idle", {31'b0, result_valid}, 32'd0);

      // Asynchronous reset in the middle of RUN.
      sw_val = 8'h77;
      sw_en = 1'b1;
      applyStimulus(8);
      checkOutput("rst_pre_busy", {31'b0, busy}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rst_A", {24'b0, A}, 32'd0);
      checkOutput("rst_en", {31'b0, en}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_valid", {31'b0, result_valid}, 32'd0);
      checkOutput("rst_found", {31'b0, found}, 32'd0);
      checkOutput("rst_err", {31'b0, err}, 32'd0);
      sw_en = 1'b0;
      applyStimulus(2);
      reset = 1'b1;
      applyStimulus(12);
      checkOutput("rst_after_en", {31'b0, en}, 32'd0);
      checkOutput("rst_after_busy", {31'b0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
